mouse_click_decoder: RTL and testbench

Sits directly downstream of the mouse front-end in the clk75MHz pixel domain. It consumes the raw cursor position (x, y) and the left button level. It produces:
- a clamped, tear-free cursor position for the cursor renderer;
- hover information against a fixed set of on-screen menu buttons;
- a single-cycle click pulse, generated only for a press-and-release on the same button.

The game FSM uses the click outputs for menu and lobby selection.

---
 rtl/mouse_ui_pkg.sv | 34 +++
 rtl/mouse_click_decoder_if.sv | 30 +++
 rtl/mouse_debounce.sv | 54 +++++
 rtl/mouse_click_decoder.sv | 143 ++++++++++++++
 tb/tb_mouse_click_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_ui_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_ui_pkg
// Description : Shared types and constants for the mouse click decoder:
//               button count, button rectangle geometry and click FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_ui_pkg;

  localparam int NUM_BTN = 4;

  typedef struct packed {
    logic [11:0] x0;
    logic [11:0] y0;
    logic [11:0] x1;
    logic [11:0] y1;
  } btn_rect_t;

  // Menu buttons share one column and are stacked downwards in 80-pixel steps.
  localparam btn_rect_t BTN_RECTS [NUM_BTN] = '{
    '{12'd100, 12'd200, 12'd299, 12'd259},
    '{12'd100, 12'd280, 12'd299, 12'd339},
    '{12'd100, 12'd360, 12'd299, 12'd419},
    '{12'd100, 12'd440, 12'd299, 12'd499}
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    HELD_OUT = 2'd2
  } click_state_t;

endpackage
`default_nettype wire

// File: rtl/mouse_click_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : mouse_click_decoder_if
// Description : Bundle between the mouse front-end side (master) and the
//               click decoder (slave): raw position/button in, decoded out.
// Revision    : 1.0 - initial release
// ============================================================================
interface mouse_click_decoder_if;
  logic        left_in;
  logic [11:0] x_in;
  logic [11:0] y_in;
  logic [11:0] cursor_x;
  logic [11:0] cursor_y;
  logic        pressed;
  logic        hover_valid;
  logic [1:0]  hover_id;
  logic        click;
  logic [1:0]  click_id;

  modport master (
    output left_in, x_in, y_in,
    input  cursor_x, cursor_y, pressed, hover_valid, hover_id, click, click_id
  );

  modport slave (
    input  left_in, x_in, y_in,
    output cursor_x, cursor_y, pressed, hover_valid, hover_id, click, click_id
  );
endinterface
`default_nettype wire

// File: rtl/mouse_debounce.sv
`default_nettype none
// ============================================================================
// Module      : mouse_debounce
// Description : Two-flop synchroniser for the asynchronous button level
//               followed by a stable-count debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_debounce #(
  parameter int DEBOUNCE_CYCLES = 75000
) (
  input  wire logic clk75MHz,
  input  wire logic rst,
  input  wire logic left_in,
  output logic      pressed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_left_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;

  // Bring the button level into the pixel domain.
  always_ff @(posedge clk75MHz) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_left_s <= 1'b0;
    end else begin
      r_sync1  <= left_in;
      r_left_s <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk75MHz) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else if (r_left_s == r_pressed) begin
      r_cnt <= '0;
    end else if (r_cnt == C_CNT_LAST) begin
      r_pressed <= r_left_s;
      r_cnt     <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign pressed = r_pressed;

endmodule
`default_nettype wire

// File: rtl/mouse_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mouse_click_decoder
// Description : Tear-filtered, clamped cursor position, button hover hit test
//               and press/release-on-same-button click detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_click_decoder
  import mouse_ui_pkg::*;
#(
  parameter int H_RES           = 1024,
  parameter int V_RES           = 768,
  parameter int DEBOUNCE_CYCLES = 75000
) (
  input  wire logic            clk75MHz,
  input  wire logic            rst,
  mouse_click_decoder_if.slave bus
);

  localparam logic [11:0] C_X_MAX = 12'(H_RES - 1);
  localparam logic [11:0] C_Y_MAX = 12'(V_RES - 1);

  logic         w_pressed;
  logic [11:0]  r_x_q;
  logic [11:0]  r_y_q;
  logic [11:0]  r_cursor_x;
  logic [11:0]  r_cursor_y;
  logic         w_hit;
  logic [1:0]   w_hit_id;
  logic         r_hover_valid;
  logic [1:0]   r_hover_id;
  click_state_t r_state;
  logic         r_pressed_d;
  logic [1:0]   r_armed_id;
  logic         r_click;
  logic [1:0]   r_click_id;
  logic         w_rise;
  logic         w_fall;

  mouse_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk75MHz (clk75MHz),
    .rst      (rst),
    .left_in  (bus.left_in),
    .pressed  (w_pressed)
  );

  // Pass a position through only once it has been seen unchanged on two cycles.
  always_ff @(posedge clk75MHz) begin
    if (rst) begin
      r_x_q      <= '0;
      r_y_q      <= '0;
      r_cursor_x <= '0;
      r_cursor_y <= '0;
    end else begin
      r_x_q <= bus.x_in;
      r_y_q <= bus.y_in;
      if (bus.x_in == r_x_q && bus.y_in == r_y_q) begin
        r_cursor_x <= (r_x_q > C_X_MAX) ? C_X_MAX : r_x_q;
        r_cursor_y <= (r_y_q > C_Y_MAX) ? C_Y_MAX : r_y_q;
      end
    end
  end

  // Hit test; scanning downwards lets the lowest matching index win.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_id = 2'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_cursor_x >= BTN_RECTS[i].x0 && r_cursor_x <= BTN_RECTS[i].x1 &&
          r_cursor_y >= BTN_RECTS[i].y0 && r_cursor_y <= BTN_RECTS[i].y1) begin
        w_hit    = 1'b1;
        w_hit_id = 2'(i);
      end
    end
  end

  // Register the hover result one cycle behind the cursor.
  always_ff @(posedge clk75MHz) begin
    if (rst) begin
      r_hover_valid <= 1'b0;
      r_hover_id    <= 2'd0;
    end else begin
      r_hover_valid <= w_hit;
      r_hover_id    <= w_hit_id;
    end
  end

  assign w_rise = w_pressed & ~r_pressed_d;
  assign w_fall = ~w_pressed & r_pressed_d;

  // Click FSM: a click needs press and release over the same button.
  always_ff @(posedge clk75MHz) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pressed_d <= 1'b0;
      r_armed_id  <= 2'd0;
      r_click     <= 1'b0;
      r_click_id  <= 2'd0;
    end else begin
      r_pressed_d <= w_pressed;
      r_click     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            if (r_hover_valid) begin
              r_state    <= ARMED;
              r_armed_id <= r_hover_id;
            end else begin
              r_state <= HELD_OUT;
            end
          end
        end
        ARMED: begin
          if (w_fall) begin
            r_state <= IDLE;
            if (r_hover_valid && r_hover_id == r_armed_id) begin
              r_click    <= 1'b1;
              r_click_id <= r_armed_id;
            end
          end
        end
        HELD_OUT: begin
          if (w_fall) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cursor_x    = r_cursor_x;
  assign bus.cursor_y    = r_cursor_y;
  assign bus.pressed     = w_pressed;
  assign bus.hover_valid = r_hover_valid;
  assign bus.hover_id    = r_hover_id;
  assign bus.click       = r_click;
  assign bus.click_id    = r_click_id;

endmodule
`default_nettype wire

// File: tb/tb_mouse_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_click_decoder
// Description : Self-checking bench for mouse_click_decoder with a click
//               scoreboard fed by an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_click_decoder;

  localparam int H = 1024;
  localparam int V = 768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [1:0] exp_q[$];

  mouse_click_decoder_if bus();

  mouse_click_decoder #(
    .H_RES           (H),
    .V_RES           (V),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk75MHz (clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference: clamp to the screen, then find the lowest button containing it.
  function automatic int model_hit(int x, int y);
    int cx = (x > H - 1) ? H - 1 : x;
    int cy = (y > V - 1) ? V - 1 : y;
    for (int i = 0; i < 4; i++)
      if (cx >= 100 && cx <= 299 && cy >= 200 + 80 * i && cy <= 259 + 80 * i)
        return i;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int x, input int y);
    bus.x_in = 12'(x);
    bus.y_in = 12'(y);
  endtask

  task automatic rand_pt(output int x, output int y);
    int b, k;
    int xs[4] = '{99, 100, 299, 300};
    int ys[4] = '{-1, 0, 59, 60};
    b = $urandom_range(0, 3);
    k = $urandom_range(0, 3);
    case ($urandom_range(0, 3))
      0: begin x = $urandom_range(100, 299); y = $urandom_range(200 + 80 * b, 259 + 80 * b); end
      1: begin x = xs[k]; y = 200 + 80 * b + ys[$urandom_range(0, 3)]; end
      2: begin x = $urandom_range(0, 4095); y = $urandom_range(0, 4095); end
      default: begin x = $urandom_range(1024, 4095); y = $urandom_range(200, 259); end
    endcase
  endtask

  // Press at p, optionally pass through m, release at r; expectation from the model.
  task automatic do_click(input int px, input int py, input bit use_mid,
                          input int mx, input int my, input int rx, input int ry);
    int idp, idr;
    set_pos(px, py);
    step(6);
    @(negedge clk);
    idp = model_hit(px, py);
    check("cursor_x", int'(bus.cursor_x), (px > H - 1) ? H - 1 : px);
    check("cursor_y", int'(bus.cursor_y), (py > V - 1) ? V - 1 : py);
    check("hover_valid", int'(bus.hover_valid), (idp >= 0) ? 1 : 0);
    check("hover_id", int'(bus.hover_id), (idp >= 0) ? idp : 0);
    step(1);
    bus.left_in = 1'b1;
    step(10);
    if (use_mid) begin
      set_pos(mx, my);
      step(6);
    end
    set_pos(rx, ry);
    step(6);
    idr = model_hit(rx, ry);
    if (idp >= 0 && idp == idr) exp_q.push_back(2'(idp));
    bus.left_in = 1'b0;
    step(12);
  endtask

  // Scoreboard monitor: every click pulse must match the next expected click.
  always @(negedge clk) begin
    if (bus.click) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL click_unexpected: click=1 click_id=%0d, expected no click", bus.click_id);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (bus.click_id !== e) begin
          n_errors++;
          $display("FAIL click_id: got %0d, expected %0d", bus.click_id, e);
        end
      end
    end
  end

  initial begin
    int x, y, rx, ry, mx, my;
    bit mid, saw;

    // Reset with button held and cursor at 500.
    bus.left_in = 1'b1;
    set_pos(500, 0);
    rst = 1'b1;
    step(3);
    @(negedge clk);
    check("rst_cursor_x", int'(bus.cursor_x), 0);
    check("rst_cursor_y", int'(bus.cursor_y), 0);
    check("rst_pressed", int'(bus.pressed), 0);
    check("rst_hover_valid", int'(bus.hover_valid), 0);
    check("rst_hover_id", int'(bus.hover_id), 0);
    check("rst_click", int'(bus.click), 0);
    check("rst_click_id", int'(bus.click_id), 0);
    step(1);
    rst = 1'b0;
    step(5);
    @(negedge clk);
    check("pressed_before_6", int'(bus.pressed), 0);
    step(1);
    @(negedge clk);
    check("pressed_after_6", int'(bus.pressed), 1);
    step(1);
    bus.left_in = 1'b0;
    step(12);

    // Tear filter: alternating x never reaches the output.
    rst = 1'b1;
    set_pos(356, 0);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.x_in = (i % 2 == 0) ? 12'd100 : 12'd356;
      @(negedge clk);
      check("tear_cursor_x", int'(bus.cursor_x), 0);
      @(posedge clk);
      #1;
    end
    bus.x_in = 12'd150;
    step(1);
    @(negedge clk);
    check("tear_hold_plus1", int'(bus.cursor_x), 0);
    step(1);
    @(negedge clk);
    check("tear_hold_plus2", int'(bus.cursor_x), 150);
    step(1);

    // Clamp beyond the screen.
    set_pos(4095, 4095);
    step(5);
    @(negedge clk);
    check("clamp_x", int'(bus.cursor_x), 1023);
    check("clamp_y", int'(bus.cursor_y), 767);
    check("clamp_hover_valid", int'(bus.hover_valid), 0);
    check("clamp_hover_id", int'(bus.hover_id), 0);
    step(1);

    // Valid click on button 0.
    do_click(150, 230, 1'b0, 0, 0, 150, 230);

    // Short glitch never changes pressed.
    saw = 1'b0;
    bus.left_in = 1'b1;
    step(2);
    bus.left_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.pressed) saw = 1'b1;
    end
    check("glitch_pressed", int'(saw), 0);
    step(1);

    // Drag onto a button, mismatched release, leave and return.
    do_click(50, 50, 1'b0, 0, 0, 150, 230);
    do_click(150, 230, 1'b0, 0, 0, 150, 310);
    do_click(150, 230, 1'b1, 150, 310, 150, 230);
    do_click(200, 470, 1'b1, 4095, 4095, 299, 440);

    // Randomized press/move/release sequences.
    for (int n = 0; n < 24; n++) begin
      rand_pt(x, y);
      if ($urandom_range(0, 1) == 1) begin
        rx = x; ry = y;
      end else begin
        rand_pt(rx, ry);
      end
      mid = ($urandom_range(0, 2) == 0);
      rand_pt(mx, my);
      do_click(x, y, mid, mx, my, rx, ry);
    end

    step(4);
    check("clicks_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
